// File: rtl/andor_clk_rst_gen.sv
// Lock-filtered, staggered per-channel reset release with per-channel clock-enable dividers.
// Define ANDOR_CRG_LOSS_CNT_EN to build the saturating lock-loss event counter on LOSS_CNT.
module andor_clk_rst_gen #(
   parameter int NUM_CH      = 4,
   parameter int DIV_WIDTH   = 16,
   parameter int LOCK_FILTER = 255,
   parameter int RST_STAGGER = 4
) (
   input  logic                        FAB_CLK,
   input  logic                        FAB_RESET,
   input  logic                        PLLLOCK,
   input  logic [NUM_CH*DIV_WIDTH-1:0] DIV_VAL,
   input  logic                        DIV_LOAD,
   input  logic                        LOCK_LOST_CLR,
   output logic [NUM_CH-1:0]           CLK_EN,
   output logic [NUM_CH-1:0]           RST_OUT,
   output logic                        READY,
   output logic                        LOCK_LOST,
   output logic [7:0]                  LOSS_CNT
);

   typedef enum logic [1:0] {WAIT_LOCK, FILTER, RELEASE, RUN} state_t;

   state_t               state_q, state_d;
   logic [1:0]           sync_q, sync_d;
   logic                 lock_s;
   logic [15:0]          filt_q, filt_d;
   logic [15:0]          rel_q, rel_d;
   logic [NUM_CH-1:0]    rst_q, rst_d;
   logic                 ready_q, ready_d;
   logic                 lock_lost_q, lock_lost_d;
   logic                 loss_evt;
   logic [DIV_WIDTH-1:0] shadow_q [NUM_CH];
   logic [DIV_WIDTH-1:0] shadow_d [NUM_CH];
   logic [DIV_WIDTH-1:0] active_q [NUM_CH];
   logic [DIV_WIDTH-1:0] active_d [NUM_CH];
   logic [DIV_WIDTH-1:0] cnt_q    [NUM_CH];
   logic [DIV_WIDTH-1:0] cnt_d    [NUM_CH];

   // Channel i stays in reset until t cycles since channel 0 released reach i*RST_STAGGER.
   function automatic logic [NUM_CH-1:0] release_mask(input logic [15:0] t);
      logic [NUM_CH-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_CH; i++) m[i] = (t < 16'(i * RST_STAGGER));
      return m;
   endfunction

   assign lock_s = sync_q[1];

   always_comb begin
      sync_d      = {sync_q[0], PLLLOCK};
      state_d     = state_q;
      filt_d      = filt_q;
      rel_d       = rel_q;
      rst_d       = rst_q;
      ready_d     = ready_q;
      loss_evt    = 1'b0;
      case (state_q)
         WAIT_LOCK: begin
            rst_d   = '1;
            ready_d = 1'b0;
            filt_d  = '0;
            if (lock_s) state_d = FILTER;
         end
         FILTER: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               filt_d  = '0;
            end else if (filt_q == 16'(LOCK_FILTER - 1)) begin
               state_d = RELEASE;
               rel_d   = '0;
               rst_d   = release_mask(16'd0);
            end else begin
               filt_d = filt_q + 16'd1;
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               loss_evt = 1'b1;
            end else if (!rst_q[NUM_CH-1]) begin
               state_d = RUN;
               ready_d = 1'b1;
            end else begin
               rel_d = rel_q + 16'd1;
               rst_d = release_mask(rel_d);
            end
         end
         RUN: begin
            if (!lock_s) loss_evt = 1'b1;
         end
         default: state_d = WAIT_LOCK;
      endcase
      if (loss_evt) begin
         state_d = WAIT_LOCK;
         rst_d   = '1;
         ready_d = 1'b0;
         filt_d  = '0;
      end
      // A loss event beats a simultaneous clear so no event is ever silently dropped.
      lock_lost_d = loss_evt ? 1'b1 : (LOCK_LOST_CLR ? 1'b0 : lock_lost_q);
   end

   // Divide values change only at a wrap or in reset, so no period is ever cut short or stretched.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      CLK_EN   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (DIV_LOAD) shadow_d[i] = DIV_VAL[i*DIV_WIDTH +: DIV_WIDTH];
         if (rst_q[i] || rst_d[i] || (cnt_q[i] == active_q[i])) begin
            cnt_d[i]    = '0;
            active_d[i] = shadow_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
         end
         CLK_EN[i] = ~rst_q[i] & (cnt_q[i] == active_q[i]);
      end
   end

   always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
      if (FAB_RESET) begin
         state_q     <= WAIT_LOCK;
         sync_q      <= '0;
         filt_q      <= '0;
         rel_q       <= '0;
         rst_q       <= '1;
         ready_q     <= 1'b0;
         lock_lost_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= '1;
            active_q[i] <= '1;
            cnt_q[i]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         filt_q      <= filt_d;
         rel_q       <= rel_d;
         rst_q       <= rst_d;
         ready_q     <= ready_d;
         lock_lost_q <= lock_lost_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         cnt_q       <= cnt_d;
      end
   end

   assign RST_OUT   = rst_q;
   assign READY     = ready_q;
   assign LOCK_LOST = lock_lost_q;

`ifdef ANDOR_CRG_LOSS_CNT_EN
   logic [7:0] loss_cnt_q, loss_cnt_d;

   always_comb begin
      loss_cnt_d = loss_cnt_q;
      if (loss_evt) begin
         if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
      end else if (LOCK_LOST_CLR) begin
         loss_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
      if (FAB_RESET) loss_cnt_q <= 8'd0;
      else           loss_cnt_q <= loss_cnt_d;
   end

   assign LOSS_CNT = loss_cnt_q;
`else
   assign LOSS_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_andor_clk_rst_gen.sv
// Self-checking bench for andor_clk_rst_gen: a time-since-release model checked every cycle,
// plus hand-computed edge-accurate expectations for the lock, stagger, divider and reset scenarios.
module tb_andor_clk_rst_gen;

   localparam int NUM_CH      = 2;
   localparam int DIV_WIDTH   = 8;
   localparam int LOCK_FILTER = 8;
   localparam int RST_STAGGER = 4;
`ifdef ANDOR_CRG_LOSS_CNT_EN
   localparam int EXP_LOSS = 255;
`else
   localparam int EXP_LOSS = 0;
`endif

   logic                        FAB_CLK       = 1'b0;
   logic                        FAB_RESET     = 1'b0;
   logic                        PLLLOCK       = 1'b0;
   logic [NUM_CH*DIV_WIDTH-1:0] DIV_VAL       = '0;
   logic                        DIV_LOAD      = 1'b0;
   logic                        LOCK_LOST_CLR = 1'b0;
   logic [NUM_CH-1:0]           CLK_EN;
   logic [NUM_CH-1:0]           RST_OUT;
   logic                        READY;
   logic                        LOCK_LOST;
   logic [7:0]                  LOSS_CNT;

   int vectors     = 0;
   int miscompares = 0;

   andor_clk_rst_gen #(
      .NUM_CH     (NUM_CH),
      .DIV_WIDTH  (DIV_WIDTH),
      .LOCK_FILTER(LOCK_FILTER),
      .RST_STAGGER(RST_STAGGER)
   ) dut (
      .FAB_CLK      (FAB_CLK),
      .FAB_RESET    (FAB_RESET),
      .PLLLOCK      (PLLLOCK),
      .DIV_VAL      (DIV_VAL),
      .DIV_LOAD     (DIV_LOAD),
      .LOCK_LOST_CLR(LOCK_LOST_CLR),
      .CLK_EN       (CLK_EN),
      .RST_OUT      (RST_OUT),
      .READY        (READY),
      .LOCK_LOST    (LOCK_LOST),
      .LOSS_CNT     (LOSS_CNT)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   // Model state: lock history, run of locked samples, cycles since channel 0 released,
   // and for each channel the edge number of its next expected enable pulse.
   int                edgeNum   = 0;
   int                run       = 0;
   int                t         = 0;
   bit                released  = 1'b0;
   bit                s1        = 1'b0;
   bit                s2        = 1'b0;
   bit                mLockLost = 1'b0;
   int                mLossCnt  = 0;
   int                shadowM   [NUM_CH];
   int                dM        [NUM_CH];
   int                nextPulse [NUM_CH];
   bit                chOn      [NUM_CH];
   logic [NUM_CH-1:0] expRst    = '1;
   logic [NUM_CH-1:0] expClk    = '0;
   logic              expReady  = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, actual, expected);
      end
   endtask

   task automatic modelStep();
      bit l;
      bit loss;
      bit newRst;
      if (FAB_RESET) begin
         s1 = 0; s2 = 0; released = 0; run = 0; t = 0;
         mLockLost = 0; mLossCnt = 0; expReady = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadowM[i] = 255; dM[i] = 255; chOn[i] = 0; nextPulse[i] = 0;
            expRst[i] = 1'b1; expClk[i] = 1'b0;
         end
         return;
      end
      edgeNum++;
      l  = s2;
      s2 = s1;
      s1 = PLLLOCK;
      loss = 0;
      if (!released) begin
         run = l ? run + 1 : 0;
         if (run == LOCK_FILTER + 1) begin
            released = 1;
            t = 0;
         end
      end else if (!l) begin
         released = 0;
         run = 0;
         loss = 1;
      end else begin
         t++;
      end
      if (loss) begin
         mLockLost = 1;
`ifdef ANDOR_CRG_LOSS_CNT_EN
         if (mLossCnt < 255) mLossCnt++;
`endif
      end else if (LOCK_LOST_CLR) begin
         mLockLost = 0;
         mLossCnt = 0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         newRst = !released || (t < i * RST_STAGGER);
         if (newRst) begin
            chOn[i] = 0;
            dM[i] = shadowM[i];
         end else if (!chOn[i] || edgeNum == nextPulse[i] + 1) begin
            chOn[i] = 1;
            dM[i] = shadowM[i];
            nextPulse[i] = edgeNum + dM[i];
         end
         expRst[i] = newRst;
         expClk[i] = chOn[i] && (edgeNum == nextPulse[i]);
      end
      if (DIV_LOAD) begin
         for (int i = 0; i < NUM_CH; i++) shadowM[i] = int'(DIV_VAL[i*DIV_WIDTH +: DIV_WIDTH]);
      end
      expReady = released && (t > (NUM_CH - 1) * RST_STAGGER);
   endtask

   // The model advances on every clock edge and on the asynchronous reset.
   initial begin
      forever begin
         @(posedge FAB_CLK or posedge FAB_RESET);
         modelStep();
      end
   end

   // Every falling edge, all outputs are compared with the model.
   initial begin
      forever begin
         @(negedge FAB_CLK);
         checkOutput("RST_OUT",   32'(RST_OUT),   32'(expRst));
         checkOutput("CLK_EN",    32'(CLK_EN),    32'(expClk));
         checkOutput("READY",     32'(READY),     32'(expReady));
         checkOutput("LOCK_LOST", 32'(LOCK_LOST), 32'(mLockLost));
         checkOutput("LOSS_CNT",  32'(LOSS_CNT),  32'(mLossCnt));
      end
   end

   // Waits for the next rising edge, then drives a new input set 2 ns later.
   task automatic applyStimulus(input logic rst, input logic lock, input logic [15:0] divVal,
                                input logic load, input logic clr);
      @(posedge FAB_CLK);
      #2;
      FAB_RESET     = rst;
      PLLLOCK       = lock;
      DIV_VAL       = divVal;
      DIV_LOAD      = load;
      LOCK_LOST_CLR = clr;
   endtask

   // Directed scenarios with hand-computed edge positions, each counted from the edge at which
   // the triggering input was driven.
   initial begin
      bit         found;
      logic [7:0] expSeq;

      #1 FAB_RESET = 1'b1;
      repeat (2) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("reset_rst_out",   32'(RST_OUT),   32'h3);
      checkOutput("reset_clk_en",    32'(CLK_EN),    32'h0);
      checkOutput("reset_ready",     32'(READY),     32'h0);
      checkOutput("reset_lock_lost", 32'(LOCK_LOST), 32'h0);
      checkOutput("reset_loss_cnt",  32'(LOSS_CNT),  32'h0);

      // Release reset and load ch0=3, ch1=5 while every channel is still held in reset.
      applyStimulus(0, 0, 16'h0503, 1, 0);
      applyStimulus(0, 0, 16'h0503, 0, 0);

      // Lock rises at edge k, glitches low for edges k+6/k+7: filter restarts, release at k+18.
      applyStimulus(0, 1, 16'h0503, 0, 0);
      repeat (4) applyStimulus(0, 1, 16'h0503, 0, 0);
      repeat (2) applyStimulus(0, 0, 16'h0503, 0, 0);
      applyStimulus(0, 1, 16'h0503, 0, 0);
      repeat (10) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("glitch_still_rst", 32'(RST_OUT), 32'h3);
      @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("glitch_rst0_release", 32'(RST_OUT), 32'h2);
      repeat (2) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("ch0_before_first_pulse", 32'(CLK_EN), 32'h0);
      @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("ch0_first_pulse_d3", 32'(CLK_EN), 32'h1);
      repeat (2) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("stagger_ready", 32'(READY), 32'h1);
      checkOutput("stagger_all_out", 32'(RST_OUT), 32'h0);

      // Find a ch0 pulse, then load 0 on the coinciding wrap: one more full period, then continuous.
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         @(negedge FAB_CLK);
         if (CLK_EN[0]) found = 1'b1;
      end
      checkOutput("ch0_pulse_seen", 32'(found), 32'h1);
      DIV_VAL  = 16'h0200;
      DIV_LOAD = 1'b1;
      @(posedge FAB_CLK);
      #2 DIV_LOAD = 1'b0;
      expSeq = 8'b1111_1000;
      for (int j = 0; j < 8; j++) begin
         if (j > 0) @(posedge FAB_CLK);
         @(negedge FAB_CLK);
         checkOutput($sformatf("ch0_reload_seq%0d", j), 32'(CLK_EN[0]), 32'(expSeq[j]));
      end

      // Lock drops at edge m: outputs unaffected through m+2, loss takes effect at m+3.
      applyStimulus(0, 0, 16'h0200, 0, 0);
      repeat (2) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("loss_pre_ready", 32'(READY), 32'h1);
      @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("loss_rst_out",   32'(RST_OUT),   32'h3);
      checkOutput("loss_clk_en",    32'(CLK_EN),    32'h0);
      checkOutput("loss_ready",     32'(READY),     32'h0);
      checkOutput("loss_lock_lost", 32'(LOCK_LOST), 32'h1);

      // Reacquire: flag stays sticky; then lose again with clear held high across the event.
      applyStimulus(0, 1, 16'h0200, 0, 0);
      repeat (12) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("relock_partial_release", 32'(RST_OUT), 32'h2);
      checkOutput("lock_lost_sticky", 32'(LOCK_LOST), 32'h1);
      applyStimulus(0, 0, 16'h0200, 0, 1);
      repeat (2) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("clr_before_event", 32'(LOCK_LOST), 32'h0);
      @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("set_wins_over_clr", 32'(LOCK_LOST), 32'h1);
      applyStimulus(0, 0, 16'h0200, 0, 0);
      @(negedge FAB_CLK);
      checkOutput("clr_pulse", 32'(LOCK_LOST), 32'h0);

      // 300 lock-loss events, each taken from inside the release phase.
      for (int e = 0; e < 300; e++) begin
         applyStimulus(0, 1, 16'h0200, 0, 0);
         repeat (12) @(posedge FAB_CLK);
         applyStimulus(0, 0, 16'h0200, 0, 0);
         repeat (3) @(posedge FAB_CLK);
      end
      @(negedge FAB_CLK);
      checkOutput("loss_cnt_after_300", 32'(LOSS_CNT), 32'(EXP_LOSS));

      // Asynchronous reset mid-release, then the full sequence again with maximum division.
      applyStimulus(0, 1, 16'h0200, 0, 0);
      repeat (13) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("mid_release", 32'(RST_OUT), 32'h2);
      @(posedge FAB_CLK);
      #2 FAB_RESET = 1'b1;
      #1;
      checkOutput("async_rst_out", 32'(RST_OUT), 32'h3);
      checkOutput("async_clk_en",  32'(CLK_EN),  32'h0);
      checkOutput("async_ready",   32'(READY),   32'h0);
      repeat (2) @(posedge FAB_CLK);
      #2 FAB_RESET = 1'b0;
      repeat (10) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("rerun_still_rst", 32'(RST_OUT), 32'h3);
      @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("rerun_rst0_release", 32'(RST_OUT), 32'h2);
      repeat (254) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("maxdiv_no_early_pulse", 32'(CLK_EN[0]), 32'h0);
      @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      checkOutput("maxdiv_pulse_255", 32'(CLK_EN[0]), 32'h1);
      checkOutput("rerun_ready", 32'(READY), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/andor_clk_rst_gen.md
ANDOR_CLK_RST_GEN -- requirements
Module: andor_clk_rst_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, range 1..8: number of clock-enable/reset channels.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, range 2..24: width of each channel divider value.
REQ-003 SHALL have parameter LOCK_FILTER, default 255, range 1..65535: consecutive locked cycles required before reset release.
REQ-004 SHALL have parameter RST_STAGGER, default 4, range 0..255: cycles between successive channel reset releases.
REQ-005 SHALL have port FAB_CLK  input  1  single fabric clock from the MSS CCC.
REQ-006 SHALL have port FAB_RESET  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port PLLLOCK  input  1  CCC lock, asynchronous to FAB_CLK.
REQ-008 SHALL have port DIV_VAL  input  NUM_CH*DIV_WIDTH  per-channel divide value; channel i occupies bits [i*DIV_WIDTH +: DIV_WIDTH].
REQ-009 SHALL have port DIV_LOAD  input  1  one-cycle strobe that captures DIV_VAL into the shadow registers.
REQ-010 SHALL have port LOCK_LOST_CLR  input  1  clears LOCK_LOST.
REQ-011 SHALL have port CLK_EN  output  NUM_CH  per-channel clock-enable pulses.
REQ-012 SHALL have port RST_OUT  output  NUM_CH  per-channel synchronous active-high reset.
REQ-013 SHALL have port READY  output  1  all channels out of reset.
REQ-014 SHALL have port LOCK_LOST  output  1  sticky flag: lock dropped after release began.
REQ-015 SHALL have port LOSS_CNT  output  8  lock-loss event count (see Configuration).

Function
REQ-016 SHALL synchronise PLLLOCK through two FAB_CLK flops (lock_s) before any use.
REQ-017 SHALL implement FSM states WAIT_LOCK, FILTER, RELEASE, RUN.
REQ-018 WAIT_LOCK: SHALL go to FILTER when lock_s=1, and stay otherwise.
REQ-019 FILTER: SHALL count consecutive lock_s=1 cycles, go to RELEASE at count LOCK_FILTER, and go to WAIT_LOCK with the count cleared if lock_s=0.
REQ-020 With PLLLOCK held high, RST_OUT[0] SHALL deassert on the (LOCK_FILTER+3)th rising edge after PLLLOCK rises.
REQ-021 RELEASE: RST_OUT[i] SHALL deassert i*RST_STAGGER cycles after RST_OUT[0]; with RST_STAGGER=0, all channels release together.
REQ-022 SHALL enter RUN and assert READY one cycle after RST_OUT[NUM_CH-1] deasserts.
REQ-023 On lock_s=0 in RELEASE or RUN, SHALL on the next edge assert all RST_OUT, clear READY, set LOCK_LOST and go to WAIT_LOCK.
REQ-024 Each channel SHALL hold a DIV_WIDTH-bit counter at 0 while its RST_OUT=1.
REQ-025 Out of reset, each counter SHALL increment and wrap to 0 after reaching its active divide value D.
REQ-026 CLK_EN[i] SHALL be 1 exactly in the cycles where counter==D, giving period D+1 with the first pulse D cycles after release.
REQ-027 D=0 SHALL give CLK_EN[i]=1 continuously while the channel is out of reset.
REQ-028 DIV_LOAD SHALL capture DIV_VAL into the shadow registers; each channel SHALL copy its shadow to D only at its own wrap, or while in reset, so no short or long pulse is ever produced.
REQ-029 DIV_LOAD coincident with a wrap SHALL take effect at the following wrap.
REQ-030 LOCK_LOST_CLR coincident with a new loss event SHALL leave LOCK_LOST=1 (set wins).
REQ-031 CLK_EN SHALL be 0 whenever the corresponding RST_OUT=1.

Reset
REQ-032 FAB_RESET=1 SHALL force, asynchronously: FSM=WAIT_LOCK, sync flops=0, counters=0, CLK_EN=0, RST_OUT=all 1s, READY=0, LOCK_LOST=0, LOSS_CNT=0.
REQ-033 FAB_RESET=1 SHALL force shadow and active D registers to all 1s (maximum division).
REQ-034 FAB_RESET asserted mid-RELEASE or mid-RUN SHALL return RST_OUT to all 1s immediately, without waiting for a clock edge.

Configuration
REQ-035 With macro ANDOR_CRG_LOSS_CNT_EN defined, LOSS_CNT SHALL increment, saturating at 255, on each REQ-023 event, and SHALL be cleared by LOCK_LOST_CLR.
REQ-036 Without ANDOR_CRG_LOSS_CNT_EN, LOSS_CNT SHALL be constant 0, with no counter logic; all other behaviour SHALL be identical.

Verification
REQ-037 NUM_CH=2, LOCK_FILTER=8, RST_STAGGER=4, PLLLOCK rises after reset -> RST_OUT[0] falls on edge 11, RST_OUT[1] on edge 15, READY=1 on edge 16.
REQ-038 PLLLOCK glitches low for 2 cycles during FILTER -> filter restarts; RST_OUT stays all 1s until 8 fresh locked cycles have elapsed.
REQ-039 DIV_VAL ch0=3 in RUN -> CLK_EN[0] pulses every 4 cycles; then DIV_LOAD with 0 -> CLK_EN[0] held high from the next wrap, with no truncated period.
REQ-040 PLLLOCK drops in RUN -> all RST_OUT=1, CLK_EN=0, READY=0, LOCK_LOST=1 within 3 edges; LOCK_LOST_CLR pulse -> LOCK_LOST=0.
REQ-041 ANDOR_CRG_LOSS_CNT_EN defined, 300 lock-loss events -> LOSS_CNT=255; macro undefined -> LOSS_CNT=0 throughout.
REQ-042 FAB_RESET asserted mid-RELEASE, between clock edges -> RST_OUT all 1s before the next edge; full sequence repeats after deassertion.
